rst_seq_gen: RTL and testbench
==============================

// Module: rst_seq_gen
// PURPOSE
//   Reset sequencer feeding i_sync_rst of top and its sub-domains. Synchronises an
//   async active-high board reset into i_clk, holds the main sync reset for a fixed
//   count, releases NUM_DOMAINS domain resets staggered in time, then flags done.
//   Also serves a level-request/pulse-ack soft-reset handshake.
// PARAMETERS
//   SYNC_STAGES     2  synchroniser flops on reset deassertion (>=2)
//   HOLD_CYCLES     2  cycles o_sync_rst stays high after the synchronised deassert (>=1)
//   NUM_DOMAINS     3  number of staggered domain resets (>=1)
//   STAGGER_CYCLES  4  cycles between consecutive domain releases (>=1)
//   SOFT_RST_CYCLES 8  cycles all resets stay asserted for a soft reset (>=1)
//   Any out-of-range value -> $error at elaboration.
// PORTS
//   i_clk           in   1            clock
//   i_async_rst     in   1            asynchronous active-high reset
//   i_soft_rst_req  in   1            soft-reset request, level, synchronous to i_clk
//   o_soft_rst_ack  out  1            1-cycle ack pulse: soft reset applied
//   o_sync_rst      out  1            main synchronous reset, drives top i_sync_rst
//   o_dom_rst       out  NUM_DOMAINS  per-domain sync resets, bit 0 released first
//   o_rst_done      out  1            1 = every reset released, sequence complete
// BEHAVIOUR
//   Reset: i_async_rst=1 forces, without a clock edge: sync chain all 1, state HOLD,
//     counter 0, o_sync_rst=1, o_dom_rst all 1, o_rst_done=0, o_soft_rst_ack=0,
//     req_armed=1. This applies mid-sequence too; sequence restarts from scratch.
//   Sync chain: after async deassert, each edge shifts a 0 in. E0 = first edge
//     capturing 0. Chain output rst_s falls after edge E0+SYNC_STAGES-1.
//   FSM HOLD: counter held 0 while rst_s=1, else +1 per edge. On the edge where it
//     reaches HOLD_CYCLES -> RELEASE; o_sync_rst and o_dom_rst[0] fall on that edge.
//     Defaults: after edge E0+3.
//   FSM RELEASE: o_dom_rst[i] falls STAGGER_CYCLES edges after o_dom_rst[i-1].
//     On the edge after the last release -> DONE, o_rst_done=1.
//     Defaults: dom[1] after E0+7, dom[2] after E0+11, done after E0+12.
//     Released bits never re-assert except via SOFT or i_async_rst.
//   FSM DONE: outputs hold. If i_soft_rst_req=1 and req_armed=1 at an edge:
//     -> SOFT; o_sync_rst=1, o_dom_rst all 1, o_rst_done=0 on that edge; req_armed=0.
//   FSM SOFT: counts SOFT_RST_CYCLES edges; on the last one -> HOLD (counter 0,
//     rst_s already 0, so counting starts next edge); o_soft_rst_ack=1 for exactly
//     that one cycle. Then HOLD/RELEASE run as after power-on.
//     Defaults, request sampled at edge S: ack high after S+8, o_sync_rst falls after
//     S+10, o_rst_done after S+19.
//   req_armed: set when i_soft_rst_req is sampled 0 at any edge. A request held high
//     across ack therefore cannot retrigger; it needs >=1 low cycle first.
//   i_soft_rst_req is ignored in HOLD/RELEASE/SOFT (no ack, no timing change) except
//     for updating req_armed.
//   Counter width $clog2(max(HOLD,STAGGER,SOFT)+1); no wrap occurs in legal use.
//   All outputs are registered; none is combinational from an input.
// TESTING
//   1 Power-on: i_async_rst=1 3 cycles, released between edges -> o_sync_rst,dom[0]
//     fall after E0+3, dom[1] after E0+7, dom[2] after E0+11, done=1 after E0+12.
//   2 i_async_rst pulsed after E0+5 -> outputs reset immediately, no edge needed;
//     after release the full test-1 timing repeats from the new E0.
//   3 DONE, req=1 at edge S, dropped after ack -> resets high and done=0 after S,
//     single-cycle ack after S+8, o_sync_rst falls after S+10, done after S+19.
//   4 req held high 40 cycles -> exactly one ack; later req low 1 cycle then high
//     -> second soft reset, same timing as 3.
//   5 req 1-cycle pulse during RELEASE -> ignored: no ack, test-1 timing unchanged.
//   6 NUM_DOMAINS=1, HOLD_CYCLES=1 -> o_sync_rst,dom[0] fall after E0+2, done after E0+3.

Source files
------------

// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises the board reset, holds the main sync reset, releases
// domain resets one at a time, then flags done. Also serves a soft-reset handshake.
module rst_seq_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 2,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 4,
  parameter int SOFT_RST_CYCLES = 8
) (
  input  logic                   i_clk,
  input  logic                   i_async_rst,
  input  logic                   i_soft_rst_req,
  output logic                   o_soft_rst_ack,
  output logic                   o_sync_rst,
  output logic [NUM_DOMAINS-1:0] o_dom_rst,
  output logic                   o_rst_done
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAXC   = (MAX_HS > SOFT_RST_CYCLES) ? MAX_HS : SOFT_RST_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = $clog2(NUM_DOMAINS + 1);

  if (SYNC_STAGES < 2)     begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");     end
  if (HOLD_CYCLES < 1)     begin : g_bad_hold  $error("HOLD_CYCLES must be >= 1");     end
  if (NUM_DOMAINS < 1)     begin : g_bad_dom   $error("NUM_DOMAINS must be >= 1");     end
  if (STAGGER_CYCLES < 1)  begin : g_bad_stag  $error("STAGGER_CYCLES must be >= 1");  end
  if (SOFT_RST_CYCLES < 1) begin : g_bad_soft  $error("SOFT_RST_CYCLES must be >= 1"); end

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_DONE, S_SOFT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_s;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   sync_n, done_n, ack_n, armed, armed_n;
  logic [NUM_DOMAINS-1:0] dom_n;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) sync_q <= '1;
    else             sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end
  assign rst_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state          <= S_HOLD;
      cnt            <= '0;
      idx            <= '0;
      o_sync_rst     <= 1'b1;
      o_dom_rst      <= '1;
      o_rst_done     <= 1'b0;
      o_soft_rst_ack <= 1'b0;
      armed          <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      o_sync_rst     <= sync_n;
      o_dom_rst      <= dom_n;
      o_rst_done     <= done_n;
      o_soft_rst_ack <= ack_n;
      armed          <= armed_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sync_n  = o_sync_rst;
    dom_n   = o_dom_rst;
    done_n  = o_rst_done;
    ack_n   = 1'b0;
    // A request must be seen low once before it can trigger again
    armed_n = i_soft_rst_req ? armed : 1'b1;
    case (state)
      S_HOLD: begin
        if (rst_s) begin
          cnt_n = '0;
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_n  = S_RELEASE;
          cnt_n    = '0;
          idx_n    = IW'(1);
          sync_n   = 1'b0;
          dom_n[0] = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (idx == IW'(NUM_DOMAINS)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if (cnt == CW'(STAGGER_CYCLES - 1)) begin
          dom_n = o_dom_rst & ~(NUM_DOMAINS'(1) << idx);
          idx_n = idx + IW'(1);
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (i_soft_rst_req && armed) begin
          state_n = S_SOFT;
          cnt_n   = '0;
          sync_n  = 1'b1;
          dom_n   = '1;
          done_n  = 1'b0;
          armed_n = 1'b0;
        end
      end
      S_SOFT: begin
        // rst_s is already low here, so HOLD starts counting on the next edge
        if (cnt == CW'(SOFT_RST_CYCLES - 1)) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          ack_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: event-time model (release edge, ack edge) checked every cycle,
// plus hand-computed timing points for power-on, async pulse, soft reset and N=1.
module tb_rst_seq_gen;

  localparam int SYNC = 2, HOLD = 2, ND = 3, ST = 4, SOFT = 8;
  localparam int HOLD2 = 1;
  localparam longint BIG = 64'd1 << 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          req2 = 1'b0;
  logic          ack, sync_rst, done;
  logic [ND-1:0] dom;
  logic          ack2, sync2, done2;
  logic [0:0]    dom2;

  int n_checks = 0;
  int n_pass   = 0;

  rst_seq_gen #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .NUM_DOMAINS(ND),
                .STAGGER_CYCLES(ST), .SOFT_RST_CYCLES(SOFT)) dut (
    .i_clk(clk), .i_async_rst(rst), .i_soft_rst_req(req),
    .o_soft_rst_ack(ack), .o_sync_rst(sync_rst), .o_dom_rst(dom), .o_rst_done(done));

  rst_seq_gen #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD2), .NUM_DOMAINS(1),
                .STAGGER_CYCLES(ST), .SOFT_RST_CYCLES(SOFT)) dut2 (
    .i_clk(clk), .i_async_rst(rst), .i_soft_rst_req(req2),
    .o_soft_rst_ack(ack2), .o_sync_rst(sync2), .o_dom_rst(dom2), .o_rst_done(done2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
  endtask

  // ---------------- behavioural model: everything derives from the release edge
  longint edge_n = 0;
  bit     in_rst = 1'b1;
  bit     armed  = 1'b1;
  longint t_rel  = BIG;
  longint t_rel2 = BIG;
  longint ack_at = -1;

  function automatic longint done_at(longint tr, int nd);
    return tr + longint'((nd - 1) * ST) + 1;
  endfunction

  function automatic logic [31:0] exp_dom(longint n, longint tr, int nd);
    logic [31:0] v = '0;
    for (int i = 0; i < nd; i++) v[i] = (n < tr + longint'(i * ST));
    return v;
  endfunction

  always @(posedge clk) begin
    logic r_s, q_s;
    r_s = rst;
    q_s = req;
    edge_n++;
    if (r_s) begin
      in_rst = 1'b1; t_rel = BIG; t_rel2 = BIG; ack_at = -1; armed = 1'b1;
    end else if (in_rst) begin
      in_rst = 1'b0;
      t_rel  = edge_n + SYNC + HOLD - 1;
      t_rel2 = edge_n + SYNC + HOLD2 - 1;
      if (!q_s) armed = 1'b1;
    end else if (edge_n - 1 >= done_at(t_rel, ND) && q_s && armed) begin
      ack_at = edge_n + SOFT;
      t_rel  = edge_n + SOFT + HOLD;
      armed  = 1'b0;
    end else if (!q_s) begin
      armed = 1'b1;
    end
    #1;
    if (in_rst) begin
      chk("m_sync", {31'b0, sync_rst}, 32'd1);
      chk("m_dom",  {29'b0, dom},      32'h7);
      chk("m_done", {31'b0, done},     32'd0);
      chk("m_ack",  {31'b0, ack},      32'd0);
      chk("m2_dom", {31'b0, dom2},     32'd1);
      chk("m2_done", {31'b0, done2},   32'd0);
    end else begin
      chk("m_sync", {31'b0, sync_rst}, {31'b0, edge_n < t_rel});
      chk("m_dom",  {29'b0, dom},      exp_dom(edge_n, t_rel, ND));
      chk("m_done", {31'b0, done},     {31'b0, edge_n >= done_at(t_rel, ND)});
      chk("m_ack",  {31'b0, ack},      {31'b0, edge_n == ack_at});
      chk("m2_dom", {31'b0, dom2},     exp_dom(edge_n, t_rel2, 1));
      chk("m2_done", {31'b0, done2},   {31'b0, edge_n >= done_at(t_rel2, 1)});
    end
    chk("m2_sync", {31'b0, sync2}, {31'b0, in_rst || edge_n < t_rel2});
    chk("m2_ack",  {31'b0, ack2},  32'd0);
  end

  // ---------------- hand-computed power-on timing, k = edges after E0
  task automatic run_seq(input int from, input int to, input int pulse_k);
    for (int k = from; k <= to; k++) begin
      @(posedge clk); #2;
      chk($sformatf("lit_sync_k%0d", k), {31'b0, sync_rst}, {31'b0, k < 3});
      chk($sformatf("lit_dom_k%0d", k),  {29'b0, dom},
          {29'b0, k < 11, k < 7, k < 3});
      chk($sformatf("lit_done_k%0d", k), {31'b0, done}, {31'b0, k >= 12});
      chk($sformatf("lit_ack_k%0d", k),  {31'b0, ack},  32'd0);
      chk($sformatf("lit2_dom_k%0d", k), {31'b0, dom2}, {31'b0, k < 2});
      chk($sformatf("lit2_done_k%0d", k), {31'b0, done2}, {31'b0, k >= 3});
      if (k == pulse_k) begin
        @(negedge clk); req = 1'b1;
      end else if (k == pulse_k + 1) begin
        @(negedge clk); req = 1'b0;
      end
    end
  endtask

  initial begin
    int acks;
    // Test 1: power-on
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("por_sync", {31'b0, sync_rst}, 32'd1);
      chk("por_dom",  {29'b0, dom},      32'h7);
    end
    @(negedge clk); rst = 1'b0;
    run_seq(0, 12, -1);

    // Test 2: async pulse mid-sequence
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_seq(0, 5, -1);
    @(negedge clk); rst = 1'b1; #1;
    chk("async_sync", {31'b0, sync_rst}, 32'd1);
    chk("async_dom",  {29'b0, dom},      32'h7);
    chk("async_done", {31'b0, done},     32'd0);
    chk("async2_sync", {31'b0, sync2},   32'd1);
    @(negedge clk); rst = 1'b0;
    run_seq(0, 12, -1);

    // Test 3: soft reset, request dropped after ack
    @(negedge clk); req = 1'b1;
    for (int j = 0; j <= 19; j++) begin
      @(posedge clk); #2;
      case (j)
        0: begin
          chk("soft_s0_sync", {31'b0, sync_rst}, 32'd1);
          chk("soft_s0_dom",  {29'b0, dom},      32'h7);
          chk("soft_s0_done", {31'b0, done},     32'd0);
        end
        7:  chk("soft_s7_ack",   {31'b0, ack},      32'd0);
        8:  chk("soft_s8_ack",   {31'b0, ack},      32'd1);
        9:  begin
          chk("soft_s9_ack",  {31'b0, ack},      32'd0);
          chk("soft_s9_sync", {31'b0, sync_rst}, 32'd1);
        end
        10: chk("soft_s10_sync", {31'b0, sync_rst}, 32'd0);
        18: chk("soft_s18_done", {31'b0, done},     32'd0);
        19: chk("soft_s19_done", {31'b0, done},     32'd1);
        default: ;
      endcase
      if (j == 8) begin @(negedge clk); req = 1'b0; end
    end

    // Test 4: held request gives one ack; re-arm needs a low cycle
    @(negedge clk); req = 1'b1;
    acks = 0;
    for (int j = 0; j < 40; j++) begin @(posedge clk); #2; acks += int'(ack); end
    chk("held_acks", acks, 1);
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    acks = 0;
    for (int j = 0; j < 25; j++) begin @(posedge clk); #2; acks += int'(ack); end
    chk("rearm_acks", acks, 1);
    chk("rearm_done", {31'b0, done}, 32'd1);
    @(negedge clk); req = 1'b0;

    // Test 5: request pulse during RELEASE is ignored
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_seq(0, 12, 5);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) < 2) rst = 1'b1;
      if ($urandom_range(0, 4) == 0) req = ~req;
    end
    @(negedge clk); req = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
